// File: rtl/mac_rw_arbiter.sv
// Read/write request arbiter for the memory access controller: QoS first, then
// direction streaks, with an age-based starvation override feeding a one-entry command slice.
module mac_rw_arbiter #(
    parameter int AW           = 32,
    parameter int MAX_STREAK   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iMAC_ValidRd,
    input  logic [AW-1:0] iMAC_AddrRd,
    input  logic [3:0]    iMAC_TagRd,
    input  logic [2:0]    iMAC_IdRd,
    input  logic [1:0]    iMAC_LenRd,
    input  logic [3:0]    iMAC_QoSRd,
    output logic          oMAC_ReadyRd,
    input  logic          iMAC_ValidWr,
    input  logic [AW-1:0] iMAC_AddrWr,
    input  logic [3:0]    iMAC_TagWr,
    input  logic [2:0]    iMAC_IdWr,
    input  logic [1:0]    iMAC_LenWr,
    input  logic [3:0]    iMAC_QoSWr,
    output logic          oMAC_ReadyWr,
    output logic          oCmd_Valid,
    output logic          oCmd_Write,
    output logic [AW-1:0] oCmd_Addr,
    output logic [3:0]    oCmd_Tag,
    output logic [2:0]    oCmd_Id,
    output logic [1:0]    oCmd_Len,
    input  logic          iCmd_Ready,
    output logic          oArb_Forced
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [GW-1:0] AGE_MAX    = GW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] streak, streak_next;
    logic [GW-1:0] rd_age, wr_age;
    logic          load_en;
    logic          grant_rd, grant_wr, forced;
    logic          rd_starved, wr_starved;

    assign load_en    = !oCmd_Valid || iCmd_Ready;
    assign rd_starved = iMAC_ValidRd && (rd_age >= AGE_MAX);
    assign wr_starved = iMAC_ValidWr && (wr_age >= AGE_MAX);

    // Starvation beats QoS; equal QoS keeps the current direction until its streak is spent.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        forced   = 1'b0;
        if (rd_starved) begin
            grant_rd = 1'b1;
            forced   = 1'b1;
        end else if (wr_starved) begin
            grant_wr = 1'b1;
            forced   = 1'b1;
        end else if (iMAC_ValidRd && !iMAC_ValidWr) begin
            grant_rd = 1'b1;
        end else if (!iMAC_ValidRd && iMAC_ValidWr) begin
            grant_wr = 1'b1;
        end else if (iMAC_ValidRd && iMAC_ValidWr) begin
            if (iMAC_QoSRd > iMAC_QoSWr) begin
                grant_rd = 1'b1;
            end else if (iMAC_QoSRd < iMAC_QoSWr) begin
                grant_wr = 1'b1;
            end else begin
                case (state)
                    S_RD: begin
                        if (streak < STREAK_MAX) grant_rd = 1'b1;
                        else                     grant_wr = 1'b1;
                    end
                    S_WR: begin
                        if (streak < STREAK_MAX) grant_wr = 1'b1;
                        else                     grant_rd = 1'b1;
                    end
                    default: grant_rd = 1'b1;
                endcase
            end
        end
    end

    assign oMAC_ReadyRd = !iReset && load_en && grant_rd;
    assign oMAC_ReadyWr = !iReset && load_en && grant_wr;

    always_comb begin
        state_next  = state;
        streak_next = streak;
        if (load_en) begin
            if (grant_rd) begin
                state_next = S_RD;
                if (state != S_RD)            streak_next = SW'(1);
                else if (streak < STREAK_MAX) streak_next = streak + SW'(1);
            end else if (grant_wr) begin
                state_next = S_WR;
                if (state != S_WR)            streak_next = SW'(1);
                else if (streak < STREAK_MAX) streak_next = streak + SW'(1);
            end else begin
                state_next  = S_IDLE;
                streak_next = '0;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state  <= S_IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // Ages freeze under backpressure so a stalled sequencer cannot trigger overrides.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            rd_age <= '0;
            wr_age <= '0;
        end else begin
            if (!iMAC_ValidRd)             rd_age <= '0;
            else if (load_en) begin
                if (grant_rd)              rd_age <= '0;
                else if (rd_age < AGE_MAX) rd_age <= rd_age + GW'(1);
            end
            if (!iMAC_ValidWr)             wr_age <= '0;
            else if (load_en) begin
                if (grant_wr)              wr_age <= '0;
                else if (wr_age < AGE_MAX) wr_age <= wr_age + GW'(1);
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oCmd_Valid  <= 1'b0;
            oCmd_Write  <= 1'b0;
            oCmd_Addr   <= '0;
            oCmd_Tag    <= '0;
            oCmd_Id     <= '0;
            oCmd_Len    <= '0;
            oArb_Forced <= 1'b0;
        end else if (load_en) begin
            oArb_Forced <= forced;
            if (grant_rd) begin
                oCmd_Valid <= 1'b1;
                oCmd_Write <= 1'b0;
                oCmd_Addr  <= iMAC_AddrRd;
                oCmd_Tag   <= iMAC_TagRd;
                oCmd_Id    <= iMAC_IdRd;
                oCmd_Len   <= iMAC_LenRd;
            end else if (grant_wr) begin
                oCmd_Valid <= 1'b1;
                oCmd_Write <= 1'b1;
                oCmd_Addr  <= iMAC_AddrWr;
                oCmd_Tag   <= iMAC_TagWr;
                oCmd_Id    <= iMAC_IdWr;
                oCmd_Len   <= iMAC_LenWr;
            end else begin
                oCmd_Valid <= 1'b0;
            end
        end else begin
            oArb_Forced <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_rw_arbiter.sv
// Scoreboard bench for mac_rw_arbiter: each scenario queues the command it expects
// when it drives a request and pops/compares it when the command register updates.
module tb_mac_rw_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, wr_valid, cmd_ready;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    rd_tag, wr_tag, rd_qos, wr_qos;
    logic [2:0]    rd_id, wr_id;
    logic [1:0]    rd_len, wr_len;
    logic          rd_ready, wr_ready;
    logic          cmd_valid, cmd_write, arb_forced;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_tag;
    logic [2:0]    cmd_id;
    logic [1:0]    cmd_len;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [3:0]    tag;
        logic [2:0]    id;
        logic [1:0]    len;
        logic          forced;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t exp_c, last_c;
    int   n_checks = 0;
    int   n_fail   = 0;

    mac_rw_arbiter #(.AW(AW), .MAX_STREAK(4), .STARVE_LIMIT(16)) dut (
        .iClk(clk), .iReset(rst),
        .iMAC_ValidRd(rd_valid), .iMAC_AddrRd(rd_addr), .iMAC_TagRd(rd_tag),
        .iMAC_IdRd(rd_id), .iMAC_LenRd(rd_len), .iMAC_QoSRd(rd_qos), .oMAC_ReadyRd(rd_ready),
        .iMAC_ValidWr(wr_valid), .iMAC_AddrWr(wr_addr), .iMAC_TagWr(wr_tag),
        .iMAC_IdWr(wr_id), .iMAC_LenWr(wr_len), .iMAC_QoSWr(wr_qos), .oMAC_ReadyWr(wr_ready),
        .oCmd_Valid(cmd_valid), .oCmd_Write(cmd_write), .oCmd_Addr(cmd_addr),
        .oCmd_Tag(cmd_tag), .oCmd_Id(cmd_id), .oCmd_Len(cmd_len),
        .iCmd_Ready(cmd_ready), .oArb_Forced(arb_forced)
    );

    always #5 clk = ~clk;

    function automatic cmd_t rd_cmd(input logic f);
        return '{1'b0, rd_addr, rd_tag, rd_id, rd_len, f};
    endfunction

    function automatic cmd_t wr_cmd(input logic f);
        return '{1'b1, wr_addr, wr_tag, wr_id, wr_len, f};
    endfunction

    function automatic cmd_t act_cmd();
        return '{cmd_write, cmd_addr, cmd_tag, cmd_id, cmd_len, arb_forced};
    endfunction

    // A requester presents its next descriptor only after its current one is taken.
    task automatic next_rd();
        rd_addr = rd_addr + 32'd4;
        rd_tag  = rd_tag + 4'd1;
        rd_id   = rd_id + 3'd1;
        rd_len  = rd_len + 2'd1;
    endtask

    task automatic next_wr();
        wr_addr = wr_addr + 32'd8;
        wr_tag  = wr_tag + 4'd1;
        wr_id   = wr_id + 3'd1;
        wr_len  = wr_len + 2'd1;
    endtask

    task automatic idle(input int n);
        rd_valid  = 1'b0;
        wr_valid  = 1'b0;
        cmd_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_valid = 1'b1; wr_valid = 1'b1; rd_qos = 4'd4; wr_qos = 4'd4; cmd_ready = 1'b0;
        rd_addr = 32'h100; rd_tag = 4'd1; rd_id = 3'd2; rd_len = 2'd1;
        wr_addr = 32'h8000; wr_tag = 4'd9; wr_id = 3'd5; wr_len = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({rd_ready, wr_ready} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got rd=%b wr=%b, want 0 0", rd_ready, wr_ready);
        end
        n_checks++;
        if ({cmd_valid, act_cmd()} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b cmd=%h, want all zero", cmd_valid, act_cmd());
        end
        rst = 1'b0; rd_valid = 1'b0;
        #1;
        n_checks++;
        if ({rd_ready, wr_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL reset_first_wr_ready: got rd=%b wr=%b, want 0 1", rd_ready, wr_ready);
        end
        exp_q.push_back(wr_cmd(1'b0));
        @(posedge clk);
        #1;
        next_wr();
        exp_c = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
            n_fail++;
            $display("[TB] FAIL reset_held_cmd: got valid=%b cmd=%h, want 1 %h", cmd_valid, act_cmd(), exp_c);
        end
        // Pulse reset in the middle of the cycle while the command is stalled.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_valid, act_cmd()} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_cycle: got valid=%b cmd=%h, want all zero", cmd_valid, act_cmd());
        end
        @(posedge clk);
        #1;
        rst = 1'b0; rd_valid = 1'b1; wr_valid = 1'b1;
        #1;
        n_checks++;
        if ({rd_ready, wr_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL reset_idle_prefers_rd: got rd=%b wr=%b, want 1 0", rd_ready, wr_ready);
        end
        exp_q.push_back(rd_cmd(1'b0));
        @(posedge clk);
        #1;
        next_rd();
        exp_c = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
            n_fail++;
            $display("[TB] FAIL reset_first_rd_cmd: got valid=%b cmd=%h, want 1 %h", cmd_valid, act_cmd(), exp_c);
        end
    endtask

    task automatic test_read_stream();
        idle(2);
        rd_addr = 32'h100;
        rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL stream_ready[%0d]: got rd=%b wr=%b, want 1 0", i, rd_ready, wr_ready);
            end
            exp_q.push_back(rd_cmd(1'b0));
            @(posedge clk);
            #1;
            next_rd();
            exp_c = exp_q.pop_front();
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL stream_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", i, cmd_valid, act_cmd(), exp_c);
            end
        end
        rd_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stream_drain: got valid=%b, want 0", cmd_valid);
        end
    endtask

    task automatic test_streak();
        logic exp_rd;
        idle(2);
        rd_qos = 4'd4; wr_qos = 4'd4; rd_valid = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_rd = ((i / 4) % 2) == 0;
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== {exp_rd, !exp_rd}) begin
                n_fail++;
                $display("[TB] FAIL streak_ready[%0d]: got rd=%b wr=%b, want %b %b", i, rd_ready, wr_ready, exp_rd, !exp_rd);
            end
            exp_q.push_back(exp_rd ? rd_cmd(1'b0) : wr_cmd(1'b0));
            @(posedge clk);
            #1;
            if (exp_rd) next_rd(); else next_wr();
            exp_c = exp_q.pop_front();
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL streak_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", i, cmd_valid, act_cmd(), exp_c);
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_rd;
        idle(2);
        rd_qos = 4'd8; wr_qos = 4'd2; rd_valid = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_rd = (i != 16);
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== {exp_rd, !exp_rd}) begin
                n_fail++;
                $display("[TB] FAIL starve_ready[%0d]: got rd=%b wr=%b, want %b %b", i, rd_ready, wr_ready, exp_rd, !exp_rd);
            end
            exp_q.push_back(exp_rd ? rd_cmd(1'b0) : wr_cmd(1'b1));
            @(posedge clk);
            #1;
            if (exp_rd) next_rd(); else next_wr();
            exp_c = exp_q.pop_front();
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL starve_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", i, cmd_valid, act_cmd(), exp_c);
            end
        end
    endtask

    // The write loses once before the stall, so if stalled cycles do not age it the
    // override lands on the 16th grant after release.
    task automatic test_backpressure();
        logic exp_rd;
        idle(2);
        rd_qos = 4'd8; wr_qos = 4'd2; rd_valid = 1'b1; wr_valid = 1'b1; cmd_ready = 1'b0;
        #1;
        n_checks++;
        if ({rd_ready, wr_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL bp_first_ready: got rd=%b wr=%b, want 1 0", rd_ready, wr_ready);
        end
        exp_q.push_back(rd_cmd(1'b0));
        @(posedge clk);
        #1;
        next_rd();
        last_c = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || act_cmd() !== last_c) begin
            n_fail++;
            $display("[TB] FAIL bp_first_cmd: got valid=%b cmd=%h, want 1 %h", cmd_valid, act_cmd(), last_c);
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL bp_stall_ready[%0d]: got rd=%b wr=%b, want 0 0", i, rd_ready, wr_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== last_c) begin
                n_fail++;
                $display("[TB] FAIL bp_stall_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", i, cmd_valid, act_cmd(), last_c);
            end
        end
        cmd_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            exp_rd = (j != 16);
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== {exp_rd, !exp_rd}) begin
                n_fail++;
                $display("[TB] FAIL bp_resume_ready[%0d]: got rd=%b wr=%b, want %b %b", j, rd_ready, wr_ready, exp_rd, !exp_rd);
            end
            exp_q.push_back(exp_rd ? rd_cmd(1'b0) : wr_cmd(1'b1));
            @(posedge clk);
            #1;
            if (exp_rd) next_rd(); else next_wr();
            exp_c = exp_q.pop_front();
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL bp_resume_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", j, cmd_valid, act_cmd(), exp_c);
            end
        end
    endtask

    // Write preempts a read streak of 2; its fresh streak of 1 then runs to 4 before reads return.
    task automatic test_qos_preempt();
        logic exp_rd;
        idle(2);
        rd_qos = 4'd3; wr_qos = 4'd3; rd_valid = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_rd = (i < 2) || (i == 6);
            wr_qos = (i == 2) ? 4'd9 : 4'd3;
            #1;
            n_checks++;
            if ({rd_ready, wr_ready} !== {exp_rd, !exp_rd}) begin
                n_fail++;
                $display("[TB] FAIL preempt_ready[%0d]: got rd=%b wr=%b, want %b %b", i, rd_ready, wr_ready, exp_rd, !exp_rd);
            end
            exp_q.push_back(exp_rd ? rd_cmd(1'b0) : wr_cmd(1'b0));
            @(posedge clk);
            #1;
            if (exp_rd) next_rd(); else next_wr();
            exp_c = exp_q.pop_front();
            n_checks++;
            if (cmd_valid !== 1'b1 || act_cmd() !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL preempt_cmd[%0d]: got valid=%b cmd=%h, want 1 %h", i, cmd_valid, act_cmd(), exp_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_stream();
        test_streak();
        test_starvation();
        test_backpressure();
        test_qos_preempt();
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mac_rw_arbiter.md
Name: mac_rw_arbiter

Overview:
Arbitrates between the read request channel and the write request channel of the memory access controller. It issues one command at a time to the SDRAM command sequencer over a registered valid/ready command channel. Selection uses QoS first, then direction streaks that limit bus turnaround, with an age-based anti-starvation override. Write data (DataWr/MaskWr/EoD) is not routed here; only request descriptors are arbitrated.

Parameters:
AW, 32, request address width
MAX_STREAK, 4, max consecutive same-direction grants at equal QoS before switching
STARVE_LIMIT, 16, cycles a losing valid request may wait before a forced grant

Ports:
iClk  in  1  clock
iReset  in  1  asynchronous active-high reset
iMAC_ValidRd  in  1  read request valid
iMAC_AddrRd  in  AW  read address
iMAC_TagRd  in  4  read tag
iMAC_IdRd  in  3  read id
iMAC_LenRd  in  2  read burst length code
iMAC_QoSRd  in  4  read QoS, higher = more urgent
oMAC_ReadyRd  out  1  read request accepted this cycle
iMAC_ValidWr  in  1  write request valid
iMAC_AddrWr  in  AW  write address
iMAC_TagWr  in  4  write tag
iMAC_IdWr  in  3  write id
iMAC_LenWr  in  2  write burst length code
iMAC_QoSWr  in  4  write QoS
oMAC_ReadyWr  out  1  write request accepted this cycle
oCmd_Valid  out  1  command register holds a command
oCmd_Write  out  1  1 = write, 0 = read
oCmd_Addr  out  AW  command address
oCmd_Tag  out  4  command tag
oCmd_Id  out  3  command id
oCmd_Len  out  2  command length code
iCmd_Ready  in  1  sequencer accepts command
oArb_Forced  out  1  one-cycle pulse: last grant was a starvation override

Behaviour:
- Reset (async, immediate): oCmd_Valid=0, all oCmd_* fields=0, oArb_Forced=0, state=S_IDLE, streak=0, both age counters=0. A command pending at reset is dropped. Ready outputs are combinational and are 0 while iReset is high.
- load_en = !oCmd_Valid | iCmd_Ready. The command register loads only when load_en is high. The register is a one-entry slice: latency is 1 cycle from request handshake to oCmd_Valid, and full throughput of 1 command/cycle is possible.
- oMAC_ReadyRd = load_en & grant_rd, and oMAC_ReadyWr = load_en & grant_wr. At most one is high per cycle. Both depend combinationally on iCmd_Ready. No ready is asserted without the matching valid.
- Grant priority, evaluated only when load_en=1:
  1. Starved side: age >= STARVE_LIMIT and valid is high. Read wins if both sides are starved. Set oArb_Forced next cycle.
  2. Single valid: that side wins.
  3. QoS differs: the higher QoS wins.
  4. QoS equal: in S_RD or S_WR with streak < MAX_STREAK, the current direction wins. If streak == MAX_STREAK, the other direction wins. In S_IDLE, read wins.
- FSM states S_IDLE, S_RD, S_WR, updated only when load_en=1:
  - Read grant: go to S_RD. streak = streak+1 if already in S_RD, else 1. Saturates at MAX_STREAK.
  - Write grant: symmetric, go to S_WR.
  - No valid request: go to S_IDLE, streak=0.
- Age counters rd_age and wr_age:
  - Increment when load_en & valid & not granted for that side.
  - Clear on grant for that side, or when that side's valid is low.
  - Saturate at STARVE_LIMIT.
  - Hold when load_en=0, so backpressure does not age requests.
- Command register: on a grant it captures the winner's addr/tag/id/len and sets oCmd_Write per direction and oCmd_Valid=1. When load_en=1 with no grant, oCmd_Valid=0 and the fields hold their old values. While oCmd_Valid=1 and iCmd_Ready=0, all oCmd_* outputs are stable.
- Simultaneous events: iCmd_Ready consuming the current command and a new grant in the same cycle is a back-to-back load with no bubble.
- QoS inputs are sampled only in the grant cycle. Requesters must hold descriptors stable while valid is high and ready is low. The arbiter does not check this.

Test Plan:
- Reset mid-operation: write a command with oCmd_Valid=1 and iCmd_Ready=0, then pulse iReset mid-cycle -> oCmd_Valid=0 immediately. After release, state is S_IDLE and the first grant at equal QoS goes to read.
- Read-only stream, iCmd_Ready=1, addresses 0x100, 0x104, 0x108 -> oMAC_ReadyRd high every cycle. oCmd_Addr shows each address one cycle later with oCmd_Write=0.
- Both valid continuously, QoS 4/4, MAX_STREAK=4 -> grant sequence R,R,R,R,W,W,W,W,R,... with no idle cycles.
- Read QoS=8, write QoS=2, both valid continuously -> 16 read grants, then a forced write grant on cycle 17 with oArb_Forced=1, then reads resume.
- Backpressure: hold iCmd_Ready=0 for 10 cycles with both valid -> both readies 0, oCmd_* unchanged, ages unchanged. Release -> normal grant resumes.
- QoS preemption: during an S_RD streak of 2 at QoS 3, raise write QoS to 9 -> the next grant is write, state becomes S_WR, streak=1.
